wstrb_lane_splitter: RTL and testbench
======================================

Name: wstrb_lane_splitter

Overview:
- Write-data downsizer stage for the AXI4 width converter path. Accepts wide W beats from the slave side and emits RATIO narrow W beats per wide beat to the master side.
- Also generates the per-lane byte-strobe masks for both data widths. These masks drive the downstream byte-to-bit mask expander directly.
- Sits between the slave-side W channel buffer and the data-merge/mask logic of the downsizer.

Parameters:
- DATA_WIDTH_IN, 64, wide (slave-side) data width in bits; power of 2, >= DATA_WIDTH_OUT, >= 32.
- DATA_WIDTH_OUT, 32, narrow (master-side) data width in bits; power of 2, >= 8.
- Derived: RATIO = DATA_WIDTH_IN/DATA_WIDTH_OUT; IDX_W = max(1, log2(RATIO)).

Ports:
- ACLK  in  1  clock, rising edge.
- sysReset  in  1  asynchronous active-low reset.
- slv_wvalid  in  1  wide beat valid.
- slv_wready  out  1  wide beat accept.
- slv_wdata  in  DATA_WIDTH_IN  wide write data.
- slv_wstrb  in  DATA_WIDTH_IN/8  wide byte strobes.
- slv_wlast  in  1  last wide beat of burst.
- slv_start_idx  in  IDX_W  first narrow lane of burst (address bits); sampled only on the first beat of a burst.
- mst_wvalid  out  1  narrow beat valid.
- mst_wready  in  1  narrow beat accept.
- mst_wdata  out  DATA_WIDTH_OUT  narrow data slice.
- mst_wstrb  out  DATA_WIDTH_OUT/8  narrow strobe slice.
- mst_wlast  out  1  last narrow beat of burst.
- shifted_slv_mask_byte  out  DATA_WIDTH_IN/8  hold_strb ANDed with the one-hot lane window at idx.
- shifted_mst_mask_byte  out  DATA_WIDTH_OUT/8  equals mst_wstrb.

Behaviour:
- State: hold_valid, hold_data, hold_strb, hold_last, idx (IDX_W), first_beat flag.
- Reset (async, sysReset=0): hold_valid=0, idx=0, first_beat=1, hold_data/strb/last=0. All outputs are therefore 0 except slv_wready=1.
- Throughput:
  - slv_wready = !hold_valid | (mst_wvalid & mst_wready & idx==RATIO-1).
  - Full throughput is one narrow beat per cycle; no bubble between wide beats.
- Accept (slv_wvalid & slv_wready):
  - load hold_*; hold_valid=1.
  - idx = first_beat ? slv_start_idx : 0.
  - first_beat = slv_wlast.
- Latency: a wide beat accepted at edge N presents its first narrow beat in cycle N+1.
- Outputs are combinational from the registers:
  - mst_wvalid = hold_valid.
  - mst_wdata = hold_data[idx*DATA_WIDTH_OUT +: DATA_WIDTH_OUT].
  - mst_wstrb = the corresponding hold_strb slice.
  - mst_wlast = hold_last & (idx==RATIO-1).
  - Masks are gated by hold_valid (all 0 when empty).
- Narrow handshake (mst_wvalid & mst_wready):
  - if idx < RATIO-1: idx = idx+1.
  - else: hold_valid = accept_this_cycle (new beat loaded as above), otherwise 0 and idx = 0.
- Zero-strobe lanes are still emitted; no beats are skipped, so burst length is preserved.
- Sub-beat index idx never wraps within a wide beat. If slv_start_idx > 0 on the first beat, that beat yields RATIO - slv_start_idx narrow beats.
- Stall:
  - mst_wready=0 holds all outputs stable.
  - mst_wvalid never deasserts without a handshake.
- Simultaneous last-lane handshake and new accept: both occur in the same edge; no beat is lost or duplicated.
- RATIO=1: idx is constant 0; the block degenerates to a one-entry pass-through register with the same handshake.
- Reset mid-burst: the in-flight beat is discarded and first_beat returns to 1.
- slv_* inputs are don't-care when slv_wvalid=0.

Decomposition:
- Shared width-converter package holds:
  - RATIO and IDX_W computation functions (clog2-based).
  - Lane-window mask function: one-hot of RATIO groups, each DATA_WIDTH_OUT/8 bits wide.
  - Assertion helpers checking the parameter legality rules above.
- One natural sub-module: lane_window_mask. It is combinational: idx -> DATA_WIDTH_IN/8 one-hot group mask, reused by the read-path upsizer.
- Sequencing remains in wstrb_lane_splitter.

Test Plan:
- 64->32, one beat, wdata=0x11112222_33334444, wstrb=0xFF, wlast=1, start_idx=0, mst_wready=1:
  - mst beats are 0x33334444/strb 0xF, then 0x11112222/strb 0xF with mst_wlast=1.
  - shifted_slv_mask_byte = 0x0F, then 0xF0.
- 128->32, start_idx=2, two-beat burst:
  - first wide beat yields exactly 2 narrow beats (lanes 2,3).
  - second yields 4 beats (lanes 0..3).
  - mst_wlast is asserted only on the 6th beat.
  - next burst again honours start_idx.
- 128->32 sparse wstrb=0x00F0, mst_wready=1:
  - 4 narrow beats with strb 0x0, 0xF, 0x0, 0x0.
  - shifted_slv_mask_byte = 0x0000, 0x00F0, 0x0000, 0x0000.
- Random mst_wready backpressure, 64->32, 8-beat burst:
  - outputs stable while stalled.
  - 16 narrow beats emitted in order with correct data.
  - slv_wready high in the same cycle as each final-lane handshake; zero idle cycles when mst_wready=1.
- Reset asserted while idx=1 with hold_valid=1:
  - next cycle mst_wvalid=0, slv_wready=1, masks 0.
  - a new burst after release uses slv_start_idx.
- DATA_WIDTH_IN=DATA_WIDTH_OUT=32:
  - each beat passes through with 1-cycle latency.
  - mst_wlast=slv_wlast, and shifted_slv_mask_byte equals shifted_mst_mask_byte.

Source files
------------

// File: rtl/wstrb_lane_splitter_pkg.sv
// Shared width-converter helpers: lane ratio and index width, lane-window
// membership, and the legality rule for the wide/narrow width pair.
package wstrb_lane_splitter_pkg;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int calc_ratio(input int data_width_in, input int data_width_out);
    return data_width_in / data_width_out;
  endfunction

  // A one-lane converter still needs a 1-bit index so that ports keep a legal width
  function automatic int calc_idx_w(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

  function automatic bit widths_legal(input int data_width_in, input int data_width_out);
    return is_pow2(data_width_in) && is_pow2(data_width_out) &&
           (data_width_in >= data_width_out) && (data_width_in >= 32) &&
           (data_width_out >= 8);
  endfunction

  // True when wide-bus byte byte_idx belongs to narrow lane 'lane'
  function automatic bit in_lane_window(input int byte_idx, input int lane, input int lane_bytes);
    return (byte_idx / lane_bytes) == lane;
  endfunction

endpackage

// File: rtl/wstrb_lane_splitter_if.sv
// W-channel bundle (valid/ready/data/strobe/last) for one side of the converter.
interface wstrb_lane_splitter_if
  import wstrb_lane_splitter_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;

  modport master (output wvalid, wdata, wstrb, wlast, input wready);
  modport slave  (input wvalid, wdata, wstrb, wlast, output wready);

endinterface

// File: rtl/wstrb_lane_splitter_lane_window_mask.sv
// Combinational lane index to wide byte-mask decoder: one group of
// DATA_WIDTH_OUT/8 ones at the selected lane. Shared with the read-path upsizer.
module lane_window_mask
  import wstrb_lane_splitter_pkg::*;
#(
  parameter  int DATA_WIDTH_IN  = 64,
  parameter  int DATA_WIDTH_OUT = 32,
  localparam int RATIO          = calc_ratio(DATA_WIDTH_IN, DATA_WIDTH_OUT),
  localparam int IDX_W          = calc_idx_w(RATIO),
  localparam int STRB_IN        = DATA_WIDTH_IN / 8,
  localparam int LANE_BYTES     = DATA_WIDTH_OUT / 8
) (
  input  logic [IDX_W-1:0]   i_idx,
  output logic [STRB_IN-1:0] o_mask
);

  for (genvar b = 0; b < STRB_IN; b++) begin : g_byte
    assign o_mask[b] = in_lane_window(b, int'(i_idx), LANE_BYTES);
  end

endmodule

// File: rtl/wstrb_lane_splitter.sv
// Write-data downsizer: holds one wide W beat and replays it as narrow lanes,
// with the byte-strobe masks for both widths handed to the mask expander.
module wstrb_lane_splitter
  import wstrb_lane_splitter_pkg::*;
#(
  parameter  int DATA_WIDTH_IN  = 64,
  parameter  int DATA_WIDTH_OUT = 32,
  localparam int RATIO          = calc_ratio(DATA_WIDTH_IN, DATA_WIDTH_OUT),
  localparam int IDX_W          = calc_idx_w(RATIO),
  localparam int STRB_IN        = DATA_WIDTH_IN / 8,
  localparam int STRB_OUT       = DATA_WIDTH_OUT / 8
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  wstrb_lane_splitter_if.slave  slv,
  input  logic [IDX_W-1:0]      slv_start_idx,
  wstrb_lane_splitter_if.master mst,
  output logic [STRB_IN-1:0]    shifted_slv_mask_byte,
  output logic [STRB_OUT-1:0]   shifted_mst_mask_byte
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (!widths_legal(DATA_WIDTH_IN, DATA_WIDTH_OUT)) begin : g_bad_widths
    $error("wstrb_lane_splitter: illegal DATA_WIDTH_IN/DATA_WIDTH_OUT combination");
  end

  logic                      r_hold_valid;
  logic [DATA_WIDTH_IN-1:0]  r_hold_data;
  logic [STRB_IN-1:0]        r_hold_strb;
  logic                      r_hold_last;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_first_beat;

  logic                      w_mst_hs;
  logic                      w_last_lane;
  logic                      w_accept;
  logic [IDX_W-1:0]          w_start_idx;
  logic [STRB_IN-1:0]        w_lane_win;
  logic [DATA_WIDTH_OUT-1:0] w_lane_data;
  logic [STRB_OUT-1:0]       w_lane_strb;

  assign w_mst_hs    = r_hold_valid & mst.wready;
  assign w_last_lane = (r_idx == LAST_IDX);
  assign slv.wready  = ~r_hold_valid | (w_mst_hs & w_last_lane);
  assign w_accept    = slv.wvalid & slv.wready;
  // A single-lane converter has nowhere to start but lane 0
  assign w_start_idx = (RATIO == 1) ? '0 : slv_start_idx;

  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_strb  <= '0;
      r_hold_last  <= 1'b0;
      r_idx        <= '0;
      r_first_beat <= 1'b1;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= slv.wdata;
      r_hold_strb  <= slv.wstrb;
      r_hold_last  <= slv.wlast;
      r_idx        <= r_first_beat ? w_start_idx : '0;
      r_first_beat <= slv.wlast;
    end else if (w_mst_hs) begin
      if (w_last_lane) begin
        r_hold_valid <= 1'b0;
        r_idx        <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    w_lane_data = '0;
    w_lane_strb = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (r_idx == IDX_W'(l)) begin
        w_lane_data = r_hold_data[l*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
        w_lane_strb = r_hold_strb[l*STRB_OUT +: STRB_OUT];
      end
    end
  end

  lane_window_mask #(
    .DATA_WIDTH_IN  (DATA_WIDTH_IN),
    .DATA_WIDTH_OUT (DATA_WIDTH_OUT)
  ) u_lane_window_mask (
    .i_idx  (r_idx),
    .o_mask (w_lane_win)
  );

  assign mst.wvalid = r_hold_valid;
  assign mst.wdata  = w_lane_data;
  assign mst.wstrb  = w_lane_strb;
  assign mst.wlast  = r_hold_last & w_last_lane;

  // Masks go straight into the bit expander, so they must read zero when empty
  assign shifted_slv_mask_byte = r_hold_valid ? (r_hold_strb & w_lane_win) : '0;
  assign shifted_mst_mask_byte = r_hold_valid ? w_lane_strb : '0;

endmodule

// File: tb/tb_wstrb_lane_splitter.sv
// Bench for wstrb_lane_splitter: 64->32, 128->32 and 32->32 instances in lockstep
// against a queue model of the narrow beats each wide beat must produce.
module tb_wstrb_lane_splitter;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [15:0] slvMask;
  } narrow_t;

  logic         aclk = 1'b0;
  logic         rstN;
  int           sel;
  logic         slvValid;
  logic [127:0] slvData;
  logic [15:0]  slvStrb;
  logic         slvLast;
  logic [1:0]   startIdx;
  logic         mstReady;
  bit           randReady;

  logic         oSlvReady, oMstValid, oMstLast;
  logic [31:0]  oMstData;
  logic [3:0]   oMstStrb, oMstMask;
  logic [15:0]  oSlvMask;

  logic [7:0]   slvMaskA;
  logic [15:0]  slvMaskB;
  logic [3:0]   slvMaskC, mstMaskA, mstMaskB, mstMaskC;

  narrow_t      expQ[$];
  bit           modelFirst;
  bit           lastAccepted;
  int           checks;
  int           failures;

  always #5 aclk = ~aclk;

  wstrb_lane_splitter_if #(.DATA_W(64))  wideA ();
  wstrb_lane_splitter_if #(.DATA_W(32))  narrowA ();
  wstrb_lane_splitter_if #(.DATA_W(128)) wideB ();
  wstrb_lane_splitter_if #(.DATA_W(32))  narrowB ();
  wstrb_lane_splitter_if #(.DATA_W(32))  wideC ();
  wstrb_lane_splitter_if #(.DATA_W(32))  narrowC ();

  assign wideA.wvalid   = slvValid && (sel == 0);
  assign wideA.wdata    = slvData[63:0];
  assign wideA.wstrb    = slvStrb[7:0];
  assign wideA.wlast    = slvLast;
  assign narrowA.wready = mstReady && (sel == 0);

  assign wideB.wvalid   = slvValid && (sel == 1);
  assign wideB.wdata    = slvData;
  assign wideB.wstrb    = slvStrb;
  assign wideB.wlast    = slvLast;
  assign narrowB.wready = mstReady && (sel == 1);

  assign wideC.wvalid   = slvValid && (sel == 2);
  assign wideC.wdata    = slvData[31:0];
  assign wideC.wstrb    = slvStrb[3:0];
  assign wideC.wlast    = slvLast;
  assign narrowC.wready = mstReady && (sel == 2);

  wstrb_lane_splitter #(.DATA_WIDTH_IN(64), .DATA_WIDTH_OUT(32)) dutA (
    .ACLK (aclk), .sysReset (rstN), .slv (wideA), .slv_start_idx (startIdx[0]),
    .mst (narrowA), .shifted_slv_mask_byte (slvMaskA), .shifted_mst_mask_byte (mstMaskA)
  );

  wstrb_lane_splitter #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32)) dutB (
    .ACLK (aclk), .sysReset (rstN), .slv (wideB), .slv_start_idx (startIdx),
    .mst (narrowB), .shifted_slv_mask_byte (slvMaskB), .shifted_mst_mask_byte (mstMaskB)
  );

  wstrb_lane_splitter #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(32)) dutC (
    .ACLK (aclk), .sysReset (rstN), .slv (wideC), .slv_start_idx (startIdx[0]),
    .mst (narrowC), .shifted_slv_mask_byte (slvMaskC), .shifted_mst_mask_byte (mstMaskC)
  );

  always_comb begin
    oSlvReady = wideA.wready;
    oMstValid = narrowA.wvalid;
    oMstData  = narrowA.wdata;
    oMstStrb  = narrowA.wstrb;
    oMstLast  = narrowA.wlast;
    oSlvMask  = {8'h00, slvMaskA};
    oMstMask  = mstMaskA;
    if (sel == 1) begin
      oSlvReady = wideB.wready;
      oMstValid = narrowB.wvalid;
      oMstData  = narrowB.wdata;
      oMstStrb  = narrowB.wstrb;
      oMstLast  = narrowB.wlast;
      oSlvMask  = slvMaskB;
      oMstMask  = mstMaskB;
    end else if (sel == 2) begin
      oSlvReady = wideC.wready;
      oMstValid = narrowC.wvalid;
      oMstData  = narrowC.wdata;
      oMstStrb  = narrowC.wstrb;
      oMstLast  = narrowC.wlast;
      oSlvMask  = {12'h000, slvMaskC};
      oMstMask  = mstMaskC;
    end
  end

  function automatic int ratioOf(input int s);
    return (s == 0) ? 2 : (s == 1) ? 4 : 1;
  endfunction

  // Expand one accepted wide beat into the narrow beats it must produce
  function automatic void pushWide(input logic [127:0] d, input logic [15:0] s,
                                   input logic l, input int st);
    int          r         = ratioOf(sel);
    int          firstLane = modelFirst ? ((r == 1) ? 0 : st) : 0;
    logic [15:0] sm        = s & 16'((1 << (r * 4)) - 1);
    for (int lane = firstLane; lane < r; lane++) begin
      narrow_t e;
      e.data    = 32'(d >> (lane * 32));
      e.strb    = 4'(sm >> (lane * 4));
      e.last    = l && (lane == r - 1);
      e.slvMask = sm & (16'hF << (lane * 4));
      expQ.push_back(e);
    end
    modelFirst = l;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at the falling edge, then advance the model
  task automatic stepCycle();
    narrow_t e;
    bit expValid, expReady, consumed, accepted;
    if (randReady) mstReady = 1'($urandom_range(0, 1));
    @(negedge aclk);
    expValid = (expQ.size() != 0);
    expReady = (expQ.size() == 0) || (mstReady && expQ.size() == 1);
    checkOutput("slv_wready", 128'(oSlvReady), 128'(expReady));
    checkOutput("mst_wvalid", 128'(oMstValid), 128'(expValid));
    if (expValid) begin
      e = expQ[0];
      checkOutput("mst_wdata", 128'(oMstData), 128'(e.data));
      checkOutput("mst_wstrb", 128'(oMstStrb), 128'(e.strb));
      checkOutput("mst_wlast", 128'(oMstLast), 128'(e.last));
      checkOutput("slv_mask", 128'(oSlvMask), 128'(e.slvMask));
      checkOutput("mst_mask", 128'(oMstMask), 128'(e.strb));
    end else begin
      checkOutput("slv_mask_empty", 128'(oSlvMask), 128'(0));
      checkOutput("mst_mask_empty", 128'(oMstMask), 128'(0));
    end
    consumed     = expValid && mstReady;
    accepted     = slvValid && expReady;
    lastAccepted = accepted;
    @(posedge aclk);
    #1;
    if (rstN) begin
      if (consumed) void'(expQ.pop_front());
      if (accepted) pushWide(slvData, slvStrb, slvLast, int'(startIdx));
    end
  endtask

  // Present one wide beat and hold it until the model says it was taken
  task automatic applyStimulus(input logic [127:0] d, input logic [15:0] s,
                               input logic l, input logic [1:0] st);
    bit done = 1'b0;
    slvValid = 1'b1;
    slvData  = d;
    slvStrb  = s;
    slvLast  = l;
    startIdx = st;
    for (int n = 0; n < 64 && !done; n++) begin
      stepCycle();
      done = lastAccepted;
    end
    checkOutput("accept_timeout", 128'(done), 128'(1));
  endtask

  task automatic idleCycles(input int n);
    slvValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      slvData = {$urandom, $urandom, $urandom, $urandom};
      stepCycle();
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    checks     = 0;
    failures   = 0;
    sel        = 0;
    rstN       = 1'b0;
    slvValid   = 1'b0;
    slvData    = '0;
    slvStrb    = '0;
    slvLast    = 1'b0;
    startIdx   = '0;
    mstReady   = 1'b1;
    randReady  = 1'b0;
    modelFirst = 1'b1;

    $display("[TB] reset state");
    stepCycle();
    checkOutput("reset_wdata", 128'(oMstData), 128'(0));
    checkOutput("reset_wlast", 128'(oMstLast), 128'(0));
    rstN = 1'b1;
    idleCycles(2);

    $display("[TB] 64->32 single beat");
    applyStimulus(128'h1111_2222_3333_4444, 16'h00FF, 1'b1, 2'd0);
    idleCycles(3);

    $display("[TB] 128->32 start_idx=2 bursts");
    sel = 1;
    applyStimulus(rand128(), 16'hFFFF, 1'b0, 2'd2);
    applyStimulus(rand128(), 16'hFFFF, 1'b1, 2'd2);
    applyStimulus(rand128(), 16'hFFFF, 1'b1, 2'd2);
    idleCycles(6);

    $display("[TB] 128->32 sparse strobe");
    applyStimulus(rand128(), 16'h00F0, 1'b1, 2'd0);
    idleCycles(6);

    $display("[TB] 64->32 random backpressure burst");
    sel       = 0;
    randReady = 1'b1;
    for (int b = 0; b < 8; b++)
      applyStimulus(rand128(), 16'($urandom), b == 7, 2'd0);
    idleCycles(24);
    randReady = 1'b0;
    mstReady  = 1'b1;
    idleCycles(2);

    $display("[TB] 64->32 full-throughput burst");
    for (int b = 0; b < 8; b++)
      applyStimulus(rand128(), 16'($urandom), b == 7, 2'($urandom_range(0, 1)));
    idleCycles(4);

    $display("[TB] reset mid-burst");
    mstReady = 1'b0;
    applyStimulus(rand128(), 16'h00FF, 1'b0, 2'd0);
    slvValid = 1'b0;
    mstReady = 1'b1;
    stepCycle();
    mstReady = 1'b0;
    stepCycle();
    rstN = 1'b0;
    expQ.delete();
    modelFirst = 1'b1;
    stepCycle();
    rstN     = 1'b1;
    mstReady = 1'b1;
    applyStimulus(rand128(), 16'h00FF, 1'b1, 2'd1);
    idleCycles(3);

    $display("[TB] 32->32 pass-through");
    sel = 2;
    for (int b = 0; b < 6; b++)
      applyStimulus(rand128(), 16'($urandom), (b == 5) || ($urandom_range(0, 2) == 0), 2'd1);
    idleCycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
